// File: rtl/m_pcpi_initiator_pkg.sv
// Shared types and constants for the PCPI initiator.
// Holds the FSM state encoding, data width and default abandon time.
package m_pcpi_pkg;

   localparam int XLEN               = 32;
   localparam int TIMEOUT_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } pcpi_state_e;

   typedef struct packed {
      logic [XLEN-1:0] rd;
      logic            wr;
   } pcpi_resp_t;

endpackage

// File: rtl/m_pcpi_initiator_if.sv
// Core-request, core-response and PCPI bundle for m_pcpi_initiator.
// master = the initiator itself, slave = core plus coprocessor side.
interface m_pcpi_initiator_if;
   import m_pcpi_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_insn;
   logic [XLEN-1:0] req_rs1;
   logic [XLEN-1:0] req_rs2;

   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_rd;
   logic            resp_wr;
   logic            resp_err;

   logic            pcpi_valid;
   logic [XLEN-1:0] pcpi_insn;
   logic [XLEN-1:0] pcpi_rs1;
   logic [XLEN-1:0] pcpi_rs2;
   logic            pcpi_wr;
   logic [XLEN-1:0] pcpi_rd;
   logic            pcpi_busy;
   logic            pcpi_ready;

   modport master (
      input  req_valid, req_insn, req_rs1, req_rs2, resp_ready,
             pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
      output req_ready, resp_valid, resp_rd, resp_wr, resp_err,
             pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
   );

   modport slave (
      output req_valid, req_insn, req_rs1, req_rs2, resp_ready,
             pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
      input  req_ready, resp_valid, resp_rd, resp_wr, resp_err,
             pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
   );

endinterface

// File: rtl/m_pcpi_initiator_timeout.sv
// Idle-cycle counter for an unclaimed PCPI request (built only with PCPI_TIMEOUT_EN).
// expired is high while the count sits at TIMEOUT_CYCLES-1.
module m_pcpi_timeout
   import m_pcpi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Holding at LAST is harmless: the FSM leaves WAIT on that same cycle.
   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (inc && !expired)
         count <= count + CW'(1);
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/m_pcpi_initiator.sv
// PCPI initiator: hands one core instruction to a coprocessor and returns its result.
// Define PCPI_TIMEOUT_EN to abandon requests nobody claims (resp_err=1).
//
// state | meaning
// IDLE  | ready for a core request
// WAIT  | pcpi_valid driven, waiting for pcpi_ready (or timeout)
// RESP  | result held on resp_* until resp_ready
module m_pcpi_initiator
   import m_pcpi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input logic               clk,
   input logic               reset,
   m_pcpi_initiator_if.master bus
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] WAIT = ST_WAIT;
   localparam logic [1:0] RESP = ST_RESP;

   logic [1:0]      state;
   logic [XLEN-1:0] insn_q;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   pcpi_resp_t      resp_q;
   logic            timeout;

`ifdef PCPI_TIMEOUT_EN
   logic to_clear;
   logic to_inc;
   logic to_expired;
   logic err_q;

   assign to_clear = (state != WAIT) || bus.pcpi_busy;
   assign to_inc   = (state == WAIT) && !bus.pcpi_busy && !bus.pcpi_ready;

   m_pcpi_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (to_clear),
      .inc     (to_inc),
      .expired (to_expired)
   );

   assign timeout = to_inc && to_expired;

   // pcpi_ready takes priority over a simultaneous timeout.
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if ((state == WAIT) && (bus.pcpi_ready || timeout))
         err_q <= !bus.pcpi_ready;
   end

   assign bus.resp_err = err_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_busy;

   assign unused_busy  = bus.pcpi_busy;
   assign timeout      = 1'b0;
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         insn_q <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         resp_q <= '0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               insn_q <= bus.req_insn;
               rs1_q  <= bus.req_rs1;
               rs2_q  <= bus.req_rs2;
               state  <= WAIT;
            end
            WAIT: if (bus.pcpi_ready) begin
               resp_q.rd <= bus.pcpi_rd;
               resp_q.wr <= bus.pcpi_wr;
               state     <= RESP;
            end else if (timeout) begin
               resp_q <= '0;
               state  <= RESP;
            end
            RESP: if (bus.resp_ready)
               state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.pcpi_valid = (state == WAIT);
   assign bus.resp_valid = (state == RESP);
   assign bus.pcpi_insn  = insn_q;
   assign bus.pcpi_rs1   = rs1_q;
   assign bus.pcpi_rs2   = rs2_q;
   assign bus.resp_rd    = resp_q.rd;
   assign bus.resp_wr    = resp_q.wr;

endmodule

// File: tb/tb_m_pcpi_initiator.sv
// Directed bench for m_pcpi_initiator with a response scoreboard.
// Timeout scenario is exercised when PCPI_TIMEOUT_EN is defined.
module tb_m_pcpi_initiator;
   import m_pcpi_pkg::*;

   logic clk = 1'b0;
   logic reset;

   m_pcpi_initiator_if bus_i ();

   m_pcpi_initiator #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        wr;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] cur_insn;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] rd, input logic wr, input logic err);
      exp_t e;
      e.rd  = rd;
      e.wr  = wr;
      e.err = err;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
      chk("req_ready_idle", 32'(bus_i.req_ready), 32'd1);
      cur_insn          = insn;
      bus_i.req_valid   = 1'b1;
      bus_i.req_insn    = insn;
      bus_i.req_rs1     = rs1;
      bus_i.req_rs2     = rs2;
      tick();
      bus_i.req_valid   = 1'b0;
      bus_i.req_insn    = 32'hBAD0_0000;
      bus_i.req_rs1     = 32'hBAD0_0001;
      bus_i.req_rs2     = 32'hBAD0_0002;
      chk("pcpi_valid_rise", 32'(bus_i.pcpi_valid), 32'd1);
      chk("pcpi_insn", bus_i.pcpi_insn, insn);
      chk("pcpi_rs1", bus_i.pcpi_rs1, rs1);
      chk("pcpi_rs2", bus_i.pcpi_rs2, rs2);
   endtask

   // idle1 quiet cycles, busy cycles, idle2 quiet cycles, then one ready cycle
   task automatic respond(input int idle1, input int busy, input int idle2,
                          input logic [31:0] rd, input logic wr);
      bus_i.pcpi_rd = ~rd;
      bus_i.pcpi_wr = ~wr;
      repeat (idle1) tick();
      bus_i.pcpi_busy = 1'b1;
      repeat (busy) tick();
      bus_i.pcpi_busy = 1'b0;
      repeat (idle2) tick();
      chk("no_resp_before_ready", 32'(bus_i.resp_valid), 32'd0);
      chk("pcpi_insn_stable", bus_i.pcpi_insn, cur_insn);
      bus_i.pcpi_ready = 1'b1;
      bus_i.pcpi_rd    = rd;
      bus_i.pcpi_wr    = wr;
      tick();
      bus_i.pcpi_ready = 1'b0;
      bus_i.pcpi_rd    = 32'hDEAD_BEEF;
      bus_i.pcpi_wr    = ~wr;
   endtask

   task automatic check_resp(input string tag);
      exp_t e;
      chk({tag, "_valid"}, 32'(bus_i.resp_valid), 32'd1);
      chk({tag, "_pcpi_valid_low"}, 32'(bus_i.pcpi_valid), 32'd0);
      chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_rd"}, bus_i.resp_rd, e.rd);
         chk({tag, "_wr"}, 32'(bus_i.resp_wr), 32'(e.wr));
         chk({tag, "_err"}, 32'(bus_i.resp_err), 32'(e.err));
      end
   endtask

   task automatic consume(input string tag);
      bus_i.resp_ready = 1'b1;
      tick();
      bus_i.resp_ready = 1'b0;
      chk({tag, "_back_idle"}, 32'(bus_i.req_ready), 32'd1);
      chk({tag, "_resp_drop"}, 32'(bus_i.resp_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      reset            = 1'b1;
      bus_i.req_valid  = 1'b0;
      bus_i.req_insn   = '0;
      bus_i.req_rs1    = '0;
      bus_i.req_rs2    = '0;
      bus_i.resp_ready = 1'b0;
      bus_i.pcpi_wr    = 1'b0;
      bus_i.pcpi_rd    = '0;
      bus_i.pcpi_busy  = 1'b0;
      bus_i.pcpi_ready = 1'b0;
      tick();
      chk("rst_req_ready", 32'(bus_i.req_ready), 32'd1);
      chk("rst_pcpi_valid", 32'(bus_i.pcpi_valid), 32'd0);
      chk("rst_resp_valid", 32'(bus_i.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(bus_i.resp_err), 32'd0);
      chk("rst_resp_wr", 32'(bus_i.resp_wr), 32'd0);
      chk("rst_resp_rd", bus_i.resp_rd, 32'd0);
      chk("rst_pcpi_insn", bus_i.pcpi_insn, 32'd0);
      chk("rst_pcpi_rs1", bus_i.pcpi_rs1, 32'd0);
      chk("rst_pcpi_rs2", bus_i.pcpi_rs2, 32'd0);
      reset = 1'b0;
      tick();

      // minimum latency: ready on the first pcpi_valid cycle
      push_exp(32'h0000_1111, 1'b1, 1'b0);
      issue(32'h0000_0033, 32'd1, 32'd2);
      respond(0, 0, 0, 32'h0000_1111, 1'b1);
      check_resp("min_latency");
      consume("min_latency");

      // mul: busy then ready after 3 cycles
      push_exp(32'h0000_002A, 1'b1, 1'b0);
      issue(32'h02B5_0533, 32'd7, 32'd6);
      respond(0, 3, 0, 32'h0000_002A, 1'b1);
      check_resp("mul");
      consume("mul");

      // long busy must never time out
      push_exp(32'hFFFF_FFFF, 1'b1, 1'b0);
      issue(32'h0000_1033, 32'd3, 32'd4);
      respond(0, 40, 0, 32'hFFFF_FFFF, 1'b1);
      check_resp("long_busy");
      consume("long_busy");

      // a single busy cycle restarts the idle count
      push_exp(32'hA5A5_A5A5, 1'b0, 1'b0);
      issue(32'h0000_2033, 32'd5, 32'd9);
      respond(10, 1, 10, 32'hA5A5_A5A5, 1'b0);
      check_resp("busy_clears");
      consume("busy_clears");

      // backpressure on the response while the core keeps offering
      push_exp(32'h1234_5678, 1'b0, 1'b0);
      issue(32'h0000_3033, 32'd11, 32'd12);
      respond(2, 0, 0, 32'h1234_5678, 1'b0);
      check_resp("hold");
      bus_i.req_valid = 1'b1;
      bus_i.req_insn  = 32'hCAFE_0001;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", 32'(bus_i.resp_valid), 32'd1);
         chk("hold_rd", bus_i.resp_rd, 32'h1234_5678);
         chk("hold_wr", 32'(bus_i.resp_wr), 32'd0);
         chk("hold_req_ready", 32'(bus_i.req_ready), 32'd0);
         chk("hold_no_accept", 32'(bus_i.pcpi_valid), 32'd0);
      end
      bus_i.resp_ready = 1'b1;
      tick();
      bus_i.resp_ready = 1'b0;
      bus_i.req_valid  = 1'b0;
      chk("hold_release_idle", 32'(bus_i.req_ready), 32'd1);
      chk("hold_release_no_accept", 32'(bus_i.pcpi_valid), 32'd0);
      tick();
      chk("hold_still_idle", 32'(bus_i.pcpi_valid), 32'd0);

      // reset during WAIT aborts; a late ready is ignored
      issue(32'h0000_4033, 32'd21, 32'd22);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_pcpi_valid", 32'(bus_i.pcpi_valid), 32'd0);
      chk("abort_req_ready", 32'(bus_i.req_ready), 32'd1);
      chk("abort_resp_valid", 32'(bus_i.resp_valid), 32'd0);
      chk("abort_pcpi_insn", bus_i.pcpi_insn, 32'd0);
      bus_i.pcpi_ready = 1'b1;
      bus_i.pcpi_rd    = 32'h0000_0099;
      tick();
      bus_i.pcpi_ready = 1'b0;
      chk("abort_late_ready", 32'(bus_i.resp_valid), 32'd0);
      chk("abort_stays_idle", 32'(bus_i.req_ready), 32'd1);

      // ready on exactly the cycle the count reaches TIMEOUT_CYCLES-1
      push_exp(32'h0000_0005, 1'b1, 1'b0);
      issue(32'h0000_5033, 32'd31, 32'd32);
      respond(15, 0, 0, 32'h0000_0005, 1'b1);
      check_resp("edge_ready");
      consume("edge_ready");

`ifdef PCPI_TIMEOUT_EN
      // no responder: abandon after 16 quiet cycles
      push_exp(32'h0000_0000, 1'b0, 1'b1);
      issue(32'h0000_6033, 32'd41, 32'd42);
      bus_i.pcpi_rd = 32'h0000_FFFF;
      bus_i.pcpi_wr = 1'b1;
      lat = 0;
      while (!bus_i.resp_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("timeout_latency", 32'(lat), 32'd16);
      check_resp("timeout");
      consume("timeout");
`else
      // without the timeout, WAIT exits only on pcpi_ready
      push_exp(32'h0000_0077, 1'b1, 1'b0);
      issue(32'h0000_6033, 32'd41, 32'd42);
      respond(40, 0, 0, 32'h0000_0077, 1'b1);
      check_resp("no_timeout");
      consume("no_timeout");
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
